// File: rtl/rtc_time_set_ctrl_pkg.sv
// Shared definitions for the RTC time-set controller:
// state codes, BCD field limits, blank masks and the shadow time bundle.
package rtc_time_set_ctrl_pkg;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_SET_HRS = 2'd1;
    localparam logic [1:0] ST_SET_MIN = 2'd2;
    localparam logic [1:0] ST_COMMIT  = 2'd3;

    localparam logic [7:0] HRS_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX = 8'h59;

    localparam logic [5:0] BLANK_HRS  = 6'b110000;
    localparam logic [5:0] BLANK_MIN  = 6'b001100;
    localparam logic [5:0] BLANK_NONE = 6'b000000;

    typedef struct packed {
        logic [7:0] hrs;
        logic [7:0] min;
    } hhmm_t;

    // Two BCD digits each 0..9 and the packed value not above the field limit.
    function automatic logic bcd2_valid(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

endpackage

// File: rtl/rtc_time_set_ctrl_bcd2_wrap_inc.sv
// Two-digit BCD increment with wrap to 00 at MAX_BCD.
// Any out-of-range input collapses to 00 so a corrupt field self-heals.
module bcd2_wrap_inc
    import rtc_time_set_ctrl_pkg::*;
#(
    parameter logic [7:0] MAX_BCD = 8'h59
) (
    input  logic [7:0] val_i,
    output logic [7:0] inc_o
);

    always_comb begin
        inc_o = 8'h00;
        if (bcd2_valid(val_i, MAX_BCD) && (val_i != MAX_BCD)) begin
            if (val_i[3:0] == 4'd9) begin
                inc_o = {val_i[7:4] + 4'd1, 4'd0};
            end else begin
                inc_o = {val_i[7:4], val_i[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/rtc_time_set_ctrl.sv
// Button-driven HH:MM time-set controller for the BCD RTC counter:
// freezes the counter, edits a shadow copy, then parallel-loads it.
module rtc_time_set_ctrl
    import rtc_time_set_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_S = 30,
    parameter bit          BLINK_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_hrs_m,
    input  logic [3:0] cur_hrs_l,
    input  logic [3:0] cur_min_m,
    input  logic [3:0] cur_min_l,
    output logic       run_en,
    output logic       load,
    output logic [3:0] ld_hrs_m,
    output logic [3:0] ld_hrs_l,
    output logic [3:0] ld_min_m,
    output logic [3:0] ld_min_l,
    output logic [5:0] blank_mask,
    output logic [1:0] mode
);

    localparam logic [8:0] TMO = 9'(TIMEOUT_S);

    logic [1:0] state_q, state_d;
    logic       mode_prev_q, inc_prev_q;
    logic       mode_edge_q, mode_edge_d;
    logic       inc_edge_q, inc_edge_d;
    hhmm_t      shadow_q, shadow_d;
    logic [7:0] timer_q, timer_d;
    logic       blink_q, blink_d;

    logic [7:0] hrs_inc, min_inc;
    logic [8:0] timer_inc;

    bcd2_wrap_inc #(.MAX_BCD(HRS_MAX)) u_hrs_inc (
        .val_i (shadow_q.hrs),
        .inc_o (hrs_inc)
    );

    bcd2_wrap_inc #(.MAX_BCD(MIN_MAX)) u_min_inc (
        .val_i (shadow_q.min),
        .inc_o (min_inc)
    );

    assign mode_edge_d = btn_mode & ~mode_prev_q;
    assign inc_edge_d  = btn_inc & ~inc_prev_q;
    assign timer_inc   = {1'b0, timer_q} + 9'd1;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        timer_d  = timer_q;
        blink_d  = blink_q;
        case (state_q)
            ST_RUN: begin
                if (mode_edge_q) begin
                    state_d  = ST_SET_HRS;
                    shadow_d = '{hrs: {cur_hrs_m, cur_hrs_l},
                                 min: {cur_min_m, cur_min_l}};
                    timer_d  = 8'd0;
                    blink_d  = 1'b0;
                end
            end
            ST_SET_HRS, ST_SET_MIN: begin
                // A mode edge wins over a simultaneous inc edge.
                if (mode_edge_q) begin
                    state_d = (state_q == ST_SET_HRS) ? ST_SET_MIN : ST_COMMIT;
                    timer_d = 8'd0;
                    blink_d = 1'b0;
                end else begin
                    if (tick_1hz) begin
                        blink_d = ~blink_q;
                    end
                    if (inc_edge_q) begin
                        timer_d = 8'd0;
                        if (state_q == ST_SET_HRS) begin
                            shadow_d.hrs = hrs_inc;
                        end else begin
                            shadow_d.min = min_inc;
                        end
                    end else if (tick_1hz) begin
                        if (timer_inc >= TMO) begin
                            state_d = ST_RUN;
                            timer_d = 8'd0;
                            blink_d = 1'b0;
                        end else begin
                            timer_d = timer_inc[7:0];
                        end
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            mode_edge_q <= 1'b0;
            inc_edge_q  <= 1'b0;
            shadow_q    <= '0;
            timer_q     <= 8'd0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= btn_mode;
            inc_prev_q  <= btn_inc;
            mode_edge_q <= mode_edge_d;
            inc_edge_q  <= inc_edge_d;
            shadow_q    <= shadow_d;
            timer_q     <= timer_d;
            blink_q     <= blink_d;
        end
    end

    assign run_en   = (state_q == ST_RUN);
    assign load     = (state_q == ST_COMMIT);
    assign mode     = state_q;
    assign ld_hrs_m = shadow_q.hrs[7:4];
    assign ld_hrs_l = shadow_q.hrs[3:0];
    assign ld_min_m = shadow_q.min[7:4];
    assign ld_min_l = shadow_q.min[3:0];

    generate
        if (BLINK_EN) begin : g_blink
            assign blank_mask = !blink_q                ? BLANK_NONE :
                                (state_q == ST_SET_HRS) ? BLANK_HRS  :
                                (state_q == ST_SET_MIN) ? BLANK_MIN  :
                                                          BLANK_NONE;
        end else begin : g_noblink
            assign blank_mask = BLANK_NONE;
        end
    endgenerate

endmodule

// File: tb/tb_rtc_time_set_ctrl.sv
// Directed and random checks of rtc_time_set_ctrl against a cycle-level
// behavioural model using integer time fields (TIMEOUT_S = 3).
module tb_rtc_time_set_ctrl;

    localparam int TMO = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] cur_hrs_m = '0, cur_hrs_l = '0;
    logic [3:0] cur_min_m = '0, cur_min_l = '0;
    logic       run_en, load;
    logic [3:0] ld_hrs_m, ld_hrs_l, ld_min_m, ld_min_l;
    logic [5:0] blank_mask;
    logic [1:0] mode;

    int checks = 0;
    int fails = 0;
    int loads_seen = 0;

    // model: 0 RUN, 1 editing hours, 2 editing minutes, 3 commit
    int m_st, m_hm, m_hl, m_mm, m_ml, m_timer;
    bit m_blink, m_prev_mode, m_prev_inc, m_pend_mode, m_pend_inc;

    rtc_time_set_ctrl #(.TIMEOUT_S(TMO), .BLINK_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_hrs_m  (cur_hrs_m),
        .cur_hrs_l  (cur_hrs_l),
        .cur_min_m  (cur_min_m),
        .cur_min_l  (cur_min_l),
        .run_en     (run_en),
        .load       (load),
        .ld_hrs_m   (ld_hrs_m),
        .ld_hrs_l   (ld_hrs_l),
        .ld_min_m   (ld_min_m),
        .ld_min_l   (ld_min_l),
        .blank_mask (blank_mask),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int next_val(input int d1, input int d0, input int limit);
        int v;
        v = d1 * 10 + d0;
        if (d1 > 9 || d0 > 9 || v >= limit) return 0;
        return (v + 1) % limit;
    endfunction

    task automatic model_reset();
        m_st = 0; m_hm = 0; m_hl = 0; m_mm = 0; m_ml = 0;
        m_timer = 0; m_blink = 0;
        m_prev_mode = 0; m_prev_inc = 0; m_pend_mode = 0; m_pend_inc = 0;
    endtask

    task automatic model_update(input bit m, input bit i, input bit t);
        int v;
        case (m_st)
            0: if (m_pend_mode) begin
                m_st = 1;
                m_hm = int'(cur_hrs_m); m_hl = int'(cur_hrs_l);
                m_mm = int'(cur_min_m); m_ml = int'(cur_min_l);
                m_timer = 0; m_blink = 0;
            end
            1, 2: if (m_pend_mode) begin
                m_st = (m_st == 1) ? 2 : 3;
                m_timer = 0; m_blink = 0;
            end else begin
                if (t) m_blink = !m_blink;
                if (m_pend_inc) begin
                    m_timer = 0;
                    if (m_st == 1) begin
                        v = next_val(m_hm, m_hl, 24);
                        m_hm = v / 10; m_hl = v % 10;
                    end else begin
                        v = next_val(m_mm, m_ml, 60);
                        m_mm = v / 10; m_ml = v % 10;
                    end
                end else if (t) begin
                    m_timer++;
                    if (m_timer >= TMO) begin
                        m_st = 0; m_timer = 0; m_blink = 0;
                    end
                end
            end
            default: m_st = 0;
        endcase
        m_pend_mode = m && !m_prev_mode;
        m_pend_inc  = i && !m_prev_inc;
        m_prev_mode = m;
        m_prev_inc  = i;
    endtask

    task automatic check_all(input string tag);
        logic [5:0] em;
        em = !m_blink ? 6'b0 : (m_st == 1) ? 6'b110000 : (m_st == 2) ? 6'b001100 : 6'b0;
        chk({tag, ".run_en"}, 16'(run_en), 16'(m_st == 0));
        chk({tag, ".load"}, 16'(load), 16'(m_st == 3));
        chk({tag, ".mode"}, 16'(mode), 16'(m_st));
        chk({tag, ".blank"}, 16'(blank_mask), 16'(em));
        chk({tag, ".ld"}, {ld_hrs_m, ld_hrs_l, ld_min_m, ld_min_l},
            {4'(m_hm), 4'(m_hl), 4'(m_mm), 4'(m_ml)});
    endtask

    task automatic step(input bit m, input bit i, input bit t, input string tag);
        btn_mode = m; btn_inc = i; tick_1hz = t;
        @(posedge clk);
        model_update(m, i, t);
        #1;
        if (load) loads_seen++;
        check_all(tag);
    endtask

    task automatic press_mode(); step(1, 0, 0, "pm"); step(0, 0, 0, "pm"); endtask
    task automatic press_inc();  step(0, 1, 0, "pi"); step(0, 0, 0, "pi"); endtask
    task automatic tick();       step(0, 0, 1, "tk"); endtask

    task automatic set_cur(input logic [7:0] h, input logic [7:0] mi);
        {cur_hrs_m, cur_hrs_l} = h;
        {cur_min_m, cur_min_l} = mi;
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk) rst = 1'b1;
        step(0, 0, 0, "idle");

        // Reset while editing minutes aborts with no load.
        set_cur(8'h07, 8'h15);
        press_mode();
        press_mode();
        chk("in_set_min", 16'(mode), 16'd2);
        loads_seen = 0;
        @(negedge clk) rst = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        chk("rst_mid.run_en", 16'(run_en), 16'd1);
        chk("rst_mid.blank", 16'(blank_mask), 16'd0);
        @(negedge clk) rst = 1'b1;
        repeat (3) step(0, 0, 0, "post_rst");
        chk("rst_mid.no_load", 16'(loads_seen), 16'd0);

        // 12:34 -> 15:36 with a single load pulse.
        set_cur(8'h12, 8'h34);
        loads_seen = 0;
        press_mode();
        repeat (3) press_inc();
        press_mode();
        repeat (2) press_inc();
        press_mode();
        chk("commit.load", 16'(load), 16'd1);
        chk("commit.ld", {ld_hrs_m, ld_hrs_l, ld_min_m, ld_min_l}, 16'h1536);
        step(0, 0, 0, "after_commit");
        chk("after_commit.run_en", 16'(run_en), 16'd1);
        chk("load_count", 16'(loads_seen), 16'd1);

        // Field wrap limits.
        set_cur(8'h22, 8'h58);
        press_mode();
        press_inc();
        chk("hrs_23", {ld_hrs_m, ld_hrs_l}, 8'h23);
        press_inc();
        chk("hrs_wrap", {ld_hrs_m, ld_hrs_l}, 8'h00);
        press_mode();
        press_inc();
        chk("min_59", {ld_min_m, ld_min_l}, 8'h59);
        press_inc();
        chk("min_wrap", {ld_min_m, ld_min_l}, 8'h00);
        press_mode();
        step(0, 0, 0, "wrap_done");

        // Simultaneous mode and inc: mode wins.
        set_cur(8'h10, 8'h00);
        press_mode();
        step(1, 1, 0, "same");
        step(0, 0, 0, "same");
        chk("same.mode", 16'(mode), 16'd2);
        chk("same.hrs", {ld_hrs_m, ld_hrs_l}, 8'h10);
        press_mode();
        step(0, 0, 0, "same_done");

        // Timeout after 3 ticks with no press.
        set_cur(8'h09, 8'h41);
        loads_seen = 0;
        press_mode();
        repeat (3) tick();
        chk("tmo.mode", 16'(mode), 16'd0);
        chk("tmo.run_en", 16'(run_en), 16'd1);
        chk("tmo.ld", {ld_hrs_m, ld_hrs_l, ld_min_m, ld_min_l}, 16'h0941);
        chk("tmo.no_load", 16'(loads_seen), 16'd0);

        // Blink pattern while editing minutes.
        set_cur(8'h03, 8'h20);
        press_mode();
        press_mode();
        tick();
        chk("blink1", 16'(blank_mask), 16'b001100);
        tick();
        chk("blink2", 16'(blank_mask), 16'b000000);
        press_inc();
        tick();
        chk("blink3", 16'(blank_mask), 16'b001100);
        tick();
        chk("blink4", 16'(blank_mask), 16'b000000);
        press_mode();
        chk("blink_commit", 16'(blank_mask), 16'd0);
        step(0, 0, 0, "blink_run");
        chk("blink_run", 16'(blank_mask), 16'd0);

        // Out-of-range shadow collapses to 00 on first inc.
        set_cur(8'h25, 8'h6B);
        press_mode();
        press_inc();
        chk("oor.hrs", {ld_hrs_m, ld_hrs_l}, 8'h00);
        press_mode();
        press_inc();
        chk("oor.min", {ld_min_m, ld_min_l}, 8'h00);
        press_mode();
        step(0, 0, 0, "oor_done");

        // Random buttons, ticks and counter values.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                cur_hrs_m = 4'($urandom_range(0, 15) < 13 ? $urandom_range(0, 2) : $urandom_range(0, 15));
                cur_hrs_l = 4'($urandom_range(0, 15) < 13 ? $urandom_range(0, 9) : $urandom_range(0, 15));
                cur_min_m = 4'($urandom_range(0, 15) < 13 ? $urandom_range(0, 5) : $urandom_range(0, 15));
                cur_min_l = 4'($urandom_range(0, 15) < 13 ? $urandom_range(0, 9) : $urandom_range(0, 15));
            end
            step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
